timer_digit_loader: RTL and testbench

Sequential consumer of the keypad encoder's `data`/`valid_input` pair in the TimerInput path. Debounces each keypress, commits it exactly once per press, and shifts the digit into a 4-digit BCD entry buffer (MM:SS, least significant digit entered last). Downstream timer logic reads the buffer and the digit count.

---
 rtl/timer_digit_loader.sv | 108 ++++++++++
 tb/tb_timer_digit_loader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_digit_loader.sv
// Debounces keypad presses and shifts each committed digit into a 4-digit BCD MM:SS entry buffer.
// The first digit entered ends up in M tens; the last digit entered is S units.
module timer_digit_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  data,
  input  logic        valid_input,
  input  logic        load_en,
  input  logic        clear,
  output logic [15:0] digits,
  output logic [2:0]  digit_count,
  output logic        new_digit,
  output logic        full
);

  typedef enum logic [1:0] {IDLE, PRESS, HELD} state_t;

  localparam logic [8:0] DEB = 9'(DEBOUNCE_CYCLES);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [3:0]  captured_q;
  logic        prev_press_q;
  logic        press;
  logic        press_edge;
  logic [8:0]  cnt_inc;

  function automatic logic [2:0] sat_count(input logic [2:0] c);
    return (c >= 3'd4) ? 3'd4 : c + 3'd1;
  endfunction

  assign press      = valid_input && (data <= 4'd9);
  assign press_edge = press && !prev_press_q;
  assign cnt_inc    = {1'b0, cnt_q} + 9'd1;
  assign full       = (digit_count == 3'd4);

  // prev_press resets high so a key held through reset needs one low sample first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      captured_q   <= 4'd0;
      prev_press_q <= 1'b1;
      digits       <= 16'h0000;
      digit_count  <= 3'd0;
      new_digit    <= 1'b0;
    end else begin
      prev_press_q <= press;
      new_digit    <= 1'b0;
      if (clear) begin
        digits      <= 16'h0000;
        digit_count <= 3'd0;
        state_q     <= IDLE;
        cnt_q       <= 8'd0;
      end else begin
        case (state_q)
          IDLE: begin
            if (press_edge && load_en) begin
              captured_q <= data;
              if (DEB == 9'd1) begin
                digits      <= {digits[11:0], data};
                digit_count <= sat_count(digit_count);
                new_digit   <= 1'b1;
                cnt_q       <= 8'd0;
                state_q     <= HELD;
              end else begin
                cnt_q   <= 8'd1;
                state_q <= PRESS;
              end
            end
          end
          PRESS: begin
            if (!press || (data != captured_q) || !load_en) begin
              cnt_q   <= 8'd0;
              state_q <= IDLE;
            end else if (cnt_inc == DEB) begin
              digits      <= {digits[11:0], captured_q};
              digit_count <= sat_count(digit_count);
              new_digit   <= 1'b1;
              cnt_q       <= 8'd0;
              state_q     <= HELD;
            end else begin
              cnt_q <= cnt_inc[7:0];
            end
          end
          HELD: begin
            // Counts consecutive released samples; any press sample restarts it.
            if (press) begin
              cnt_q <= 8'd0;
            end else if (cnt_inc == DEB) begin
              cnt_q   <= 8'd0;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_inc[7:0];
            end
          end
          default: begin
            cnt_q   <= 8'd0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_digit_loader.sv
// Scoreboard bench for timer_digit_loader: expected buffer states are queued as keys are driven
// and compared whenever the DUT pulses new_digit.
module tb_timer_digit_loader;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  data = 4'd0;
  logic        valid_input = 1'b0;
  logic        load_en = 1'b1;
  logic        clear = 1'b0;
  logic [15:0] digits;
  logic [2:0]  digit_count;
  logic        new_digit;
  logic        full;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_digits = 16'h0;
  int          exp_count  = 0;
  logic [18:0] sb[$];

  timer_digit_loader #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .data(data), .valid_input(valid_input),
    .load_en(load_en), .clear(clear), .digits(digits),
    .digit_count(digit_count), .new_digit(new_digit), .full(full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Outputs are sampled on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (!rst && new_digit) begin
      if (sb.size() > 0) begin
        logic [18:0] e;
        e = sb.pop_front();
        check("sb_buffer", {13'd0, digit_count, digits}, {13'd0, e});
      end else begin
        check("spurious_pulse", {31'd0, new_digit}, 32'd0);
      end
    end
  end

  task automatic model_commit(input logic [3:0] d);
    exp_digits = {exp_digits[11:0], d};
    exp_count  = (exp_count >= 4) ? 4 : exp_count + 1;
    sb.push_back({exp_count[2:0], exp_digits});
  endtask

  task automatic model_clear();
    exp_digits = 16'h0;
    exp_count  = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid_input = 1'b0;
    clear = 1'b0;
    load_en = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    model_clear();
    cyc();
  endtask

  task automatic press_key(input logic [3:0] d, input int hi, input int lo, input bit commit);
    if (commit) model_commit(d);
    data = d;
    valid_input = 1'b1;
    for (int i = 1; i <= hi; i++) begin
      cyc();
      if (commit && i == D)     check("pulse_at_commit", {31'd0, new_digit}, 32'd1);
      if (commit && i == D + 1) check("pulse_one_cycle", {31'd0, new_digit}, 32'd0);
    end
    valid_input = 1'b0;
    repeat (lo) cyc();
  endtask

  task automatic check_outputs(input string tag, input logic [15:0] ed, input int ec);
    check({tag, "_digits"}, {16'd0, digits}, {16'd0, ed});
    check({tag, "_count"}, {29'd0, digit_count}, ec);
    check({tag, "_full"}, {31'd0, full}, {31'd0, (ec == 4)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check_outputs("reset", 16'h0000, 0);
    check("reset_new_digit", {31'd0, new_digit}, 32'd0);

    // Single press, then held long after the commit.
    press_key(4'd5, D + 20, 6, 1'b1);
    check_outputs("press5", 16'h0005, 1);

    // Fill the buffer, then overflow it.
    do_reset();
    press_key(4'd1, 6, 6, 1'b1);
    press_key(4'd2, 6, 6, 1'b1);
    press_key(4'd3, 6, 6, 1'b1);
    press_key(4'd0, 6, 6, 1'b1);
    check_outputs("fill", 16'h1230, 4);
    press_key(4'd7, 6, 6, 1'b1);
    check_outputs("overflow", 16'h2307, 4);

    // Short presses separated by a one-sample release.
    press_key(4'd8, 3, 1, 1'b0);
    press_key(4'd8, 3, 6, 1'b0);
    check_outputs("glitch", 16'h2307, 4);

    // Digit changes mid-debounce.
    data = 4'd4; valid_input = 1'b1;
    cyc();
    data = 4'd6;
    repeat (6) cyc();
    valid_input = 1'b0;
    repeat (6) cyc();
    check_outputs("data_change", 16'h2307, 4);

    // Non-digit code and entry disabled.
    press_key(4'd12, 10, 6, 1'b0);
    check_outputs("code12", 16'h2307, 4);
    load_en = 1'b0;
    press_key(4'd9, 10, 6, 1'b0);
    load_en = 1'b1;
    check_outputs("load_dis", 16'h2307, 4);

    // Clear colliding with a commit; held key must not commit afterwards.
    do_reset();
    press_key(4'd1, 6, 6, 1'b1);
    press_key(4'd2, 6, 6, 1'b1);
    check_outputs("pre_clear", 16'h0012, 2);
    data = 4'd3; valid_input = 1'b1;
    repeat (D - 1) cyc();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    model_clear();
    check_outputs("clear", 16'h0000, 0);
    check("clear_new_digit", {31'd0, new_digit}, 32'd0);
    repeat (10) cyc();
    valid_input = 1'b0;
    repeat (6) cyc();
    check_outputs("clear_held", 16'h0000, 0);
    press_key(4'd3, 6, 6, 1'b1);
    check_outputs("after_clear", 16'h0003, 1);

    // Asynchronous reset while in PRESS.
    data = 4'd9; valid_input = 1'b1;
    repeat (2) cyc();
    #2 rst = 1'b1;
    #1;
    check_outputs("rst_press", 16'h0000, 0);
    cyc();
    rst = 1'b0;
    model_clear();
    repeat (8) cyc();
    check_outputs("rst_held_key", 16'h0000, 0);
    valid_input = 1'b0;
    repeat (6) cyc();

    // Asynchronous reset while in HELD.
    model_commit(4'd4);
    data = 4'd4; valid_input = 1'b1;
    repeat (D) cyc();
    check("held_pulse", {31'd0, new_digit}, 32'd1);
    check_outputs("held_pre", 16'h0004, 1);
    repeat (2) cyc();
    #2 rst = 1'b1;
    #1;
    check_outputs("rst_held", 16'h0000, 0);
    check("rst_held_new_digit", {31'd0, new_digit}, 32'd0);
    cyc();
    rst = 1'b0;
    valid_input = 1'b0;
    repeat (6) cyc();

    check("sb_pending", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
